seq_pattern_gen: RTL

Serial pattern transmitter. Captures a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per accepted transfer, repeating it a programmable number of times with optional idle gaps between repeats. It is the source end of the serial bit-stream path and drives the team's Moore sequence detectors, such as the 110011 detector, for stimulus and loopback checking. Transfers use a valid/ready handshake so a stalling consumer is tolerated.

---
 rtl/seq_pattern_gen_pkg.sv | 17 +
 rtl/seq_pattern_gen_shift_reg.sv | 48 ++++
 rtl/seq_pattern_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// State enum is also used by benches that decode the FSM.
package seq_gen_pkg;

  localparam int PAT_W_DEF = 6;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

  localparam logic [PAT_W_DEF-1:0] DEFAULT_PATTERN = 6'b110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_gen_state_t;

endpackage

// File: rtl/seq_pattern_gen_shift_reg.sv
// Pattern holder with an MSB-first bit index; load captures, advance steps on accept.
// The index wraps to the MSB after bit 0, so a repeat needs no separate reload.
module pattern_shift_reg #(
  parameter int PAT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_adv,
  output logic             o_last,
  output logic             o_bit_nxt
);

  localparam int              IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] w_pat_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  always_comb begin
    w_pat_nxt = r_pat;
    w_idx_nxt = r_idx;
    if (i_load) begin
      w_pat_nxt = i_pattern;
      w_idx_nxt = IDX_MSB;
    end else if (i_adv) begin
      w_idx_nxt = (r_idx == '0) ? IDX_MSB : r_idx - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= '0;
      r_idx <= IDX_MSB;
    end else begin
      r_pat <= w_pat_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  assign o_last = (r_idx == '0);
  // Look-ahead bit lets the top register dout instead of muxing it combinationally.
  assign o_bit_nxt = w_pat_nxt[w_idx_nxt];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: MSB-first, repeat_n+1 copies, optional idle gaps.
// All outputs are registered from next-state values; ready=0 freezes SHIFT.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  input  logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  seq_gen_state_t   r_state;
  seq_gen_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_rep_nxt;
  logic [GAP_W-1:0] r_gap_q;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_cnt_nxt;
  logic             w_load;
  logic             w_adv;
  logic             w_done_nxt;
  logic             w_last;
  logic             w_bit_nxt;
  logic             r_dout;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;

  pattern_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_pattern (pattern),
    .i_adv     (w_adv),
    .o_last    (w_last),
    .o_bit_nxt (w_bit_nxt)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_rep_nxt     = r_rep;
    w_gap_cnt_nxt = r_gap_cnt;
    w_load        = 1'b0;
    w_adv         = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
          w_rep_nxt   = repeat_n;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (ready) begin
          w_adv = 1'b1;
          if (w_last) begin
            if (r_rep == '0) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_rep_nxt = r_rep - CNT_W'(1);
              if (r_gap_q != '0) begin
                w_state_nxt   = GAP;
                w_gap_cnt_nxt = r_gap_q;
              end
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          if (r_gap_cnt == GAP_W'(1)) w_state_nxt = SHIFT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rep     <= '0;
      r_gap_q   <= '0;
      r_gap_cnt <= '0;
      r_dout    <= 1'b0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep     <= w_rep_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_load) r_gap_q <= gap;
      r_dout    <= (w_state_nxt == SHIFT) && w_bit_nxt;
      r_vld     <= (w_state_nxt == SHIFT);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_vld;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
